// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encodings and control-bit positions for pipeline stage registers
package pipe_pkg;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: loadable {ctrl, data, rd} payload register with async active-low clear
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 2,
    parameter int CTRL_W    = 4,
    parameter int RD_W      = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          load_i,
    input  logic [CTRL_W-1:0]             ctrl_i,
    input  logic [NUM_LANES*DATA_W-1:0]   data_i,
    input  logic [RD_W-1:0]               rd_i,
    output logic [CTRL_W-1:0]             ctrl_o,
    output logic [NUM_LANES*DATA_W-1:0]   data_o,
    output logic [RD_W-1:0]               rd_o
);
    logic [CTRL_W-1:0]           ctrl_q;
    logic [NUM_LANES*DATA_W-1:0] data_q;
    logic [RD_W-1:0]             rd_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q <= '0;
            data_q <= '0;
            rd_q   <= '0;
        end else if (load_i) begin
            ctrl_q <= ctrl_i;
            data_q <= data_i;
            rd_q   <= rd_i;
        end
    end
    assign ctrl_o = ctrl_q;
    assign data_o = data_q;
    assign rd_o   = rd_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer, flush and bubble-safe ctrl
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 2,
    parameter int CTRL_W    = 4,
    parameter int RD_W      = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          start_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [CTRL_W-1:0]             ctrl_i,
    input  logic [NUM_LANES*DATA_W-1:0]   data_i,
    input  logic [RD_W-1:0]               rd_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [CTRL_W-1:0]             ctrl_o,
    output logic [NUM_LANES*DATA_W-1:0]   data_o,
    output logic [RD_W-1:0]               rd_o,
    output logic [1:0]                    occ_o
);
    logic [1:0] state_q, state_d;
    logic accept, drain, load_main, load_skid, main_from_skid;
    logic [CTRL_W-1:0]           main_ctrl, skid_ctrl, main_ctrl_d;
    logic [NUM_LANES*DATA_W-1:0] main_data, skid_data, main_data_d;
    logic [RD_W-1:0]             main_rd, skid_rd, main_rd_d;
    assign in_ready_o  = start_i & (state_q != ST_TWO) & ~flush_i;
    assign out_valid_o = start_i & (state_q != ST_EMPTY);
    assign accept      = in_valid_i & in_ready_o;
    assign drain       = out_valid_o & out_ready_i;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (start_i && flush_i) begin
            state_d = ST_EMPTY;
        end else if (start_i) begin
            case (state_q)
                ST_EMPTY: begin
                    load_main = accept;
                    state_d   = accept ? ST_ONE : ST_EMPTY;
                end
                ST_ONE: begin
                    load_main = accept & drain;
                    load_skid = accept & ~drain;
                    state_d   = (accept & ~drain) ? ST_TWO : (drain & ~accept) ? ST_EMPTY : ST_ONE;
                end
                ST_TWO: begin
                    load_main      = drain;
                    main_from_skid = drain;
                    state_d        = drain ? ST_ONE : ST_TWO;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end
    // Skid entry is older than any new input, so it refills main first
    assign main_ctrl_d = main_from_skid ? skid_ctrl : ctrl_i;
    assign main_data_d = main_from_skid ? skid_data : data_i;
    assign main_rd_d   = main_from_skid ? skid_rd   : rd_i;
    pipe_entry_reg #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_main (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .load_i(load_main),
        .ctrl_i(main_ctrl_d), .data_i(main_data_d), .rd_i(main_rd_d),
        .ctrl_o(main_ctrl), .data_o(main_data), .rd_o(main_rd)
    );
    pipe_entry_reg #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_skid (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .load_i(load_skid),
        .ctrl_i(ctrl_i), .data_i(data_i), .rd_i(rd_i),
        .ctrl_o(skid_ctrl), .data_o(skid_data), .rd_o(skid_rd)
    );
    assign ctrl_o = out_valid_o ? main_ctrl : '0;
    assign data_o = main_data;
    assign rd_o   = main_rd;
    assign occ_o  = state_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed scenario tests for pipe_stage_skid
module tb_pipe_stage_skid;
    import pipe_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n, start, flush, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  ctrl_in, ctrl_out;
    logic [63:0] data_in, data_out;
    logic [4:0]  rd_in, rd_out;
    logic [1:0]  occ;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    pipe_stage_skid dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .ctrl_i(ctrl_in),
        .data_i(data_in), .rd_i(rd_in), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .ctrl_o(ctrl_out), .data_o(data_out),
        .rd_o(rd_out), .occ_o(occ)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [4:0] rd, input logic [3:0] c);
        in_valid = 1'b1; rd_in = rd; ctrl_in = c; data_in = {59'd0, rd};
        step();
        in_valid = 1'b0;
    endtask
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ctrl_in = '0; data_in = '0; rd_in = '0;
        #12;
        checks++; if (occ !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occ); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (ctrl_out !== 4'd0 || data_out !== 64'd0 || rd_out !== 5'd0) begin errors++; $display("FAIL reset_payload got %h/%h/%h want 0", ctrl_out, data_out, rd_out); end
        @(negedge clk); rst_n = 1'b1;
        step();
    endtask
    task automatic test_single();
        start = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        ctrl_in = 4'b0001 << CTRL_REGWRITE; data_in = {32'h0000_0008, 32'hDEAD_BEEF}; rd_in = 5'd3;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
        checks++; if (ctrl_out !== 4'b0001) begin errors++; $display("FAIL single_ctrl got %b want 0001", ctrl_out); end
        checks++; if (data_out !== {32'h0000_0008, 32'hDEAD_BEEF}) begin errors++; $display("FAIL single_data got %h want 00000008deadbeef", data_out); end
        checks++; if (rd_out !== 5'd3 || occ !== 2'd1) begin errors++; $display("FAIL single_rd_occ got %0d/%0d want 3/1", rd_out, occ); end
        step();
        checks++; if (occ !== 2'd0 || out_valid !== 1'b0 || ctrl_out !== 4'd0) begin errors++; $display("FAIL single_drain got occ %0d valid %b ctrl %b want 0/0/0", occ, out_valid, ctrl_out); end
        checks++; if (rd_out !== 5'd3) begin errors++; $display("FAIL single_rd_hold got %0d want 3", rd_out); end
    endtask
    task automatic test_backpressure();
        out_ready = 1'b0;
        push(5'd1, 4'b0010);
        push(5'd2, 4'b0100);
        checks++; if (occ !== 2'd2) begin errors++; $display("FAIL bp_occ got %0d want 2", occ); end
        in_valid = 1'b1; rd_in = 5'd9; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", in_ready); end
        step();
        checks++; if (occ !== 2'd2 || rd_out !== 5'd1) begin errors++; $display("FAIL bp_hold got occ %0d rd %0d want 2/1", occ, rd_out); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (rd_out !== 5'd2 || occ !== 2'd1 || ctrl_out !== 4'b0100) begin errors++; $display("FAIL bp_second got rd %0d occ %0d ctrl %b want 2/1/0100", rd_out, occ, ctrl_out); end
        step();
        checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got occ %0d valid %b want 0/0", occ, out_valid); end
    endtask
    task automatic test_flush();
        out_ready = 1'b0;
        push(5'd4, 4'b1000);
        push(5'd5, 4'b1000);
        flush = 1'b1; in_valid = 1'b1; rd_in = 5'd6; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (occ !== 2'd0 || out_valid !== 1'b0 || ctrl_out !== 4'd0) begin errors++; $display("FAIL flush_clear got occ %0d valid %b ctrl %b want 0/0/0", occ, out_valid, ctrl_out); end
        out_ready = 1'b1;
        step();
        checks++; if (occ !== 2'd0 || out_valid !== 1'b0 || rd_out === 5'd6) begin errors++; $display("FAIL flush_dropped got occ %0d valid %b rd %0d want 0/0/not 6", occ, out_valid, rd_out); end
    endtask
    task automatic test_freeze();
        out_ready = 1'b0;
        push(5'd7, 4'b0001);
        start = 1'b0; out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; rd_in = 5'd11;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || occ !== 2'd1 || ctrl_out !== 4'd0) begin errors++; $display("FAIL freeze_%0d got valid %b ready %b occ %0d ctrl %b want 0/0/1/0", i, out_valid, in_ready, occ, ctrl_out); end
            step();
        end
        start = 1'b1; flush = 1'b0; in_valid = 1'b0; #1;
        checks++; if (out_valid !== 1'b1 || rd_out !== 5'd7 || ctrl_out !== 4'b0001) begin errors++; $display("FAIL freeze_resume got valid %b rd %0d ctrl %b want 1/7/0001", out_valid, rd_out, ctrl_out); end
        step();
        checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL freeze_once got occ %0d valid %b want 0/0", occ, out_valid); end
    endtask
    task automatic test_async_reset();
        out_ready = 1'b0;
        push(5'd12, 4'b1001);
        push(5'd13, 4'b1001);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (occ !== 2'd0 || out_valid !== 1'b0 || ctrl_out !== 4'd0 || data_out !== 64'd0 || rd_out !== 5'd0) begin errors++; $display("FAIL async_reset got occ %0d valid %b ctrl %b data %h rd %0d want all 0", occ, out_valid, ctrl_out, data_out, rd_out); end
        rst_n = 1'b1;
        step();
    endtask
    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; rd_in = 5'(i); ctrl_in = 4'b0001; data_in = 64'(i * 3); #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got %b want 1", i, in_ready); end
            step();
            checks++; if (rd_out !== 5'(i) || occ !== 2'd1 || out_valid !== 1'b1 || data_out !== 64'(i * 3)) begin errors++; $display("FAIL stream_out_%0d got rd %0d occ %0d valid %b data %h want %0d/1/1/%h", i, rd_out, occ, out_valid, data_out, i, 64'(i * 3)); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (occ !== 2'd0) begin errors++; $display("FAIL stream_end got %0d want 0", occ); end
    endtask
    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_freeze();
        test_async_reset();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
